// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults and the colour type used by the maze renderers.
// Derived line/frame totals and sync windows are pre-computed for the 640x480 mode.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register that lines raw sync/blank up with the renderer latency.
// Each bit has its own reset value so sync bits flush to their inactive level.
module sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per pixel clock; reset flushes every stage.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: scan counters, blanked col/row for the renderers,
// sync delayed to match renderer latency, and registered pin drivers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIX_LAT  = 1
) (
    input  logic       pixel_clk,
    input  logic       resetSwitch,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic       frame_start,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue
);

    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_video_on;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [2:0] w_dly_in;
    logic [2:0] w_dly_out;
    rgb_t       w_rgb_in;
    rgb_t       r_rgb;
    logic       r_hsync;
    logic       r_vsync;

    // Scan counters; vcnt advances on the same edge that wraps hcnt.
    always_ff @(posedge pixel_clk) begin
        if (!resetSwitch) begin
            r_hcnt <= 10'd0;
            r_vcnt <= 10'd0;
        end else if (r_hcnt == H_MAX) begin
            r_hcnt <= 10'd0;
            r_vcnt <= (r_vcnt == V_MAX) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
            r_vcnt <= r_vcnt;
        end
    end

    assign w_video_on  = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign w_hs_raw    = !((r_hcnt >= HS_START) && (r_hcnt <= HS_END));
    assign w_vs_raw    = !((r_vcnt >= VS_START) && (r_vcnt <= VS_END));

    // Coordinates are zeroed in blanking so renderers never index past the visible area.
    assign col         = w_video_on ? r_hcnt : 10'd0;
    assign row         = w_video_on ? r_vcnt[8:0] : 9'd0;
    assign frame_start = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

    assign w_dly_in    = {w_hs_raw, w_vs_raw, w_video_on};
    assign w_rgb_in    = {red_in, green_in, blue_in};

    sync_delay #(
        .DEPTH   (PIX_LAT),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .i_clk   (pixel_clk),
        .i_rst_n (resetSwitch),
        .i_d     (w_dly_in),
        .o_q     (w_dly_out)
    );

    // Pin register: one stage after the delay line for sync and blanked colour alike.
    always_ff @(posedge pixel_clk) begin
        if (!resetSwitch) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= rgb_t'(12'd0);
        end else begin
            r_hsync <= w_dly_out[2];
            r_vsync <= w_dly_out[1];
            r_rgb   <= w_dly_out[0] ? w_rgb_in : rgb_t'(12'd0);
        end
    end

    assign vga_hsync = r_hsync;
    assign vga_vsync = r_vsync;
    assign vga_red   = r_rgb.r;
    assign vga_green = r_rgb.g;
    assign vga_blue  = r_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a default-timing instance (PIX_LAT=1) checked against a vector table, plus two
// reduced-timing instances (32x15 raster, PIX_LAT 0 and 3) for frame-level and reset checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- default-timing instance ----------------
    logic       rst_d = 1'b0;
    logic [9:0] col_d;
    logic [8:0] row_d;
    logic       fs_d, hs_d, vs_d;
    logic [3:0] r_d, g_d, b_d;
    logic [3:0] red_in_d = 4'd0;

    vga_timing_gen #(.PIX_LAT(1)) u_dut_d (
        .pixel_clk(clk), .resetSwitch(rst_d),
        .col(col_d), .row(row_d), .frame_start(fs_d),
        .red_in(red_in_d), .green_in(4'hF), .blue_in(4'hA),
        .vga_hsync(hs_d), .vga_vsync(vs_d),
        .vga_red(r_d), .vga_green(g_d), .vga_blue(b_d)
    );

    // one-cycle registered renderer model
    always @(posedge clk) red_in_d <= col_d[3:0];

    // ---------------- reduced-timing instances ----------------
    logic       rst_s = 1'b0;
    logic [9:0] col_s [2];
    logic [8:0] row_s [2];
    logic       fs_s [2], hs_s [2], vs_s [2];
    logic [3:0] r_s [2], g_s [2], b_s [2];
    logic [3:0] ri_s [2];
    logic [3:0] rd3 [3] = '{default: 4'd0};
    int         lat_s [2] = '{0, 3};

    assign ri_s[0] = col_s[0][3:0];
    always @(posedge clk) begin
        rd3[0] <= col_s[1][3:0];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign ri_s[1] = rd3[2];

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(0)) u_dut_s0 (
        .pixel_clk(clk), .resetSwitch(rst_s),
        .col(col_s[0]), .row(row_s[0]), .frame_start(fs_s[0]),
        .red_in(ri_s[0]), .green_in(4'hF), .blue_in(4'h5),
        .vga_hsync(hs_s[0]), .vga_vsync(vs_s[0]),
        .vga_red(r_s[0]), .vga_green(g_s[0]), .vga_blue(b_s[0])
    );

    vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(3)) u_dut_s3 (
        .pixel_clk(clk), .resetSwitch(rst_s),
        .col(col_s[1]), .row(row_s[1]), .frame_start(fs_s[1]),
        .red_in(ri_s[1]), .green_in(4'hF), .blue_in(4'h5),
        .vga_hsync(hs_s[1]), .vga_vsync(vs_s[1]),
        .vga_red(r_s[1]), .vga_green(g_s[1]), .vga_blue(b_s[1])
    );

    // Expected red pin for the small raster: pixel t=c-lat-1 after release, 32x15 frame.
    function automatic logic [3:0] exp_red(input int c, input int lat);
        int t, pos;
        t = c - lat - 1;
        if (t < 0) return 4'd0;
        pos = t % 480;
        if ((pos % 32) < 16 && (pos / 32) < 8) return 4'(pos % 32);
        return 4'd0;
    endfunction

    // Runs the small instances from reset release for ncyc cycles and checks them.
    task automatic run_small(input int ncyc, input bit full);
        int prev_hs [2], prev_vs [2], hs_fall [2], hs_start [2], bad_hw [2], n_hp [2];
        int vs_fall [2], vs_w [2], last_fs [2], n_fs [2], bad_fs [2];
        int g_cnt [2], bad_rng [2], bad_red [2], first_g [2];
        for (int k = 0; k < 2; k++) begin
            prev_hs[k] = 1; prev_vs[k] = 1; hs_fall[k] = -1; hs_start[k] = -1;
            bad_hw[k] = 0; n_hp[k] = 0; vs_fall[k] = -1; vs_w[k] = -1;
            last_fs[k] = -1; n_fs[k] = 0; bad_fs[k] = 0; g_cnt[k] = 0;
            bad_rng[k] = 0; bad_red[k] = 0; first_g[k] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (c == 0) check("s_start_coord", {col_s[k], row_s[k], fs_s[k]}, {10'd0, 9'd0, 1'b1});
                if (c == 1) check("s_next_coord", {col_s[k], row_s[k], fs_s[k]}, {10'd1, 9'd0, 1'b0});
                if (hs_s[k] == 1'b0 && prev_hs[k] == 1) begin
                    if (hs_fall[k] < 0) hs_fall[k] = c;
                    hs_start[k] = c;
                end
                if (hs_s[k] == 1'b1 && prev_hs[k] == 0 && hs_start[k] >= 0) begin
                    n_hp[k]++;
                    if (c - hs_start[k] != 6) bad_hw[k]++;
                end
                if (vs_s[k] == 1'b0 && prev_vs[k] == 1 && vs_fall[k] < 0) vs_fall[k] = c;
                if (vs_s[k] == 1'b1 && prev_vs[k] == 0 && vs_fall[k] >= 0 && vs_w[k] < 0)
                    vs_w[k] = c - vs_fall[k];
                if (fs_s[k]) begin
                    if (last_fs[k] >= 0 && c - last_fs[k] != 480) bad_fs[k]++;
                    last_fs[k] = c;
                    n_fs[k]++;
                end
                if (g_s[k] != 4'd0 && first_g[k] < 0) first_g[k] = c;
                if (g_s[k] != 4'd0 && c >= lat_s[k] + 1 && c < lat_s[k] + 481) g_cnt[k]++;
                if (col_s[k] > 10'd15 || row_s[k] > 9'd7) bad_rng[k]++;
                if (r_s[k] !== exp_red(c, lat_s[k])) bad_red[k]++;
                prev_hs[k] = int'(hs_s[k]);
                prev_vs[k] = int'(vs_s[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            check("s_hs_first_fall", hs_fall[k], 21 + lat_s[k]);
            check("s_first_colour", first_g[k], lat_s[k] + 1);
            check("s_sync_colour_offset", hs_fall[k] - first_g[k], 20);
            check("s_red_align_errs", bad_red[k], 0);
            if (full) begin
                check("s_hs_width_errs", bad_hw[k], 0);
                check("s_hs_pulses", n_hp[k], 31);
                check("s_vs_first_fall", vs_fall[k], 321 + lat_s[k]);
                check("s_vs_width", vs_w[k], 64);
                check("s_fs_pulses", n_fs[k], 3);
                check("s_fs_period_errs", bad_fs[k], 0);
                check("s_active_pixels", g_cnt[k], 128);
                check("s_range_errs", bad_rng[k], 0);
            end
        end
    endtask

    typedef struct {
        int         cyc;
        logic [9:0] col;
        logic [8:0] row;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [3:0] red;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int idx, bad_rng_d, hs_fall_d, hs_rise_d;
        logic prev_hs_d;

        tbl[0]  = '{0,    10'd0,   9'd0, 1'b1, 1'b1, 1'b1, 4'd0};
        tbl[1]  = '{1,    10'd1,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[2]  = '{2,    10'd2,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[3]  = '{5,    10'd5,   9'd0, 1'b0, 1'b1, 1'b1, 4'd3};
        tbl[4]  = '{20,   10'd20,  9'd0, 1'b0, 1'b1, 1'b1, 4'd2};
        tbl[5]  = '{639,  10'd639, 9'd0, 1'b0, 1'b1, 1'b1, 4'd13};
        tbl[6]  = '{640,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd14};
        tbl[7]  = '{641,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd15};
        tbl[8]  = '{642,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[9]  = '{657,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[10] = '{658,  10'd0,   9'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[11] = '{753,  10'd0,   9'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[12] = '{754,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[13] = '{799,  10'd0,   9'd0, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[14] = '{800,  10'd0,   9'd1, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[15] = '{801,  10'd1,   9'd1, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[16] = '{805,  10'd5,   9'd1, 1'b0, 1'b1, 1'b1, 4'd3};
        tbl[17] = '{1600, 10'd0,   9'd2, 1'b0, 1'b1, 1'b1, 4'd0};
        tbl[18] = '{1603, 10'd3,   9'd2, 1'b0, 1'b1, 1'b1, 4'd1};

        // Default instance: 5 cycles of reset, pins inactive throughout.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d_rst_pins", {hs_d, vs_d, r_d, g_d, b_d}, {1'b1, 1'b1, 12'h000});
            check("d_rst_coord", {col_d, row_d, fs_d}, {10'd0, 9'd0, 1'b1});
        end
        rst_d = 1'b1;

        idx = 0; bad_rng_d = 0; hs_fall_d = -1; hs_rise_d = -1; prev_hs_d = 1'b1;
        for (int c = 0; c <= 1603; c++) begin
            if (c > 0) @(negedge clk);
            if (idx < 19 && tbl[idx].cyc == c) begin
                check($sformatf("d_vec_cyc%0d", c),
                      {col_d, row_d, fs_d, hs_d, vs_d, r_d},
                      {tbl[idx].col, tbl[idx].row, tbl[idx].fs, tbl[idx].hs, tbl[idx].vs, tbl[idx].red});
                idx++;
            end
            if (col_d > 10'd639 || row_d > 9'd479) bad_rng_d++;
            if (!hs_d && prev_hs_d && hs_fall_d < 0) hs_fall_d = c;
            if (hs_d && !prev_hs_d && hs_rise_d < 0) hs_rise_d = c;
            prev_hs_d = hs_d;
        end
        check("d_vectors_seen", idx, 19);
        check("d_range_errs", bad_rng_d, 0);
        check("d_hs_first_fall", hs_fall_d, 658);
        check("d_hs_width", hs_rise_d - hs_fall_d, 96);

        // Small instances have been held in reset since time zero.
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("s_rst_pins", {hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k]}, {1'b1, 1'b1, 12'h000});
        rst_s = 1'b1;
        run_small(1000, 1'b1);

        // Move to hcnt=24, vcnt=10 of the third frame: inside both sync pulses.
        repeat (305) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("s_pre_rst_sync_low", {hs_s[k], vs_s[k]}, 2'b00);
        rst_s = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("s_midrst_sync", {hs_s[k], vs_s[k]}, 2'b11);
            check("s_midrst_colour", {r_s[k], g_s[k], b_s[k]}, 12'h000);
            check("s_midrst_coord", {col_s[k], row_s[k], fs_s[k]}, {10'd0, 9'd0, 1'b1});
        end
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        run_small(80, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
